// File: rtl/var_delay_line.sv
// rtl/var_delay_line.sv - programmable 1..DEPTH sample delay line for offset-binary ADC samples
//
// Ports:
//   sysclk   in   1       system clock, all logic on the rising edge
//   reset    in   1       synchronous active-high reset
//   load     in   1       ADC new-sample level; its rising edge marks a new sample
//   d        in   DATA_W  input sample, valid while load is high
//   k        in   ADDR_W  delay in samples, 0 selects DEPTH
//   q        out  DATA_W  delayed sample (midscale until history covers the delay)
//   q_valid  out  1       one-cycle pulse when q updates
//   busy     out  1       RAM clear sweep in progress
//
// Optional build macro VAR_DELAY_CLEAR_EN: after reset an IDLE->CLEAR->RUN sweep
// writes midscale into every RAM word and strobes are ignored while busy.
// Without it busy is tied low and fill-based muting alone hides stale RAM data.

module var_delay_line #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 9
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] k,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W:0]   DEPTH_W  = {1'b1, {ADDR_W{1'b0}}};

    logic                load_d;
    logic                stb;
    logic [ADDR_W:0]     k_eff;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     fill;

    // stage 1: registered in the strobe cycle
    logic                v_s1;
    logic                mute_s1;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_en_p;
    logic [ADDR_W-1:0]   wr_addr_p;
    logic [DATA_W-1:0]   wr_data_p;

    // stage 2: RAM read data registered
    logic                v_s2;
    logic                mute_s2;
    logic [DATA_W-1:0]   ram_rd;

    // RAM write port (pending sample write or clear sweep)
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign stb   = load & ~load_d & ~busy;
    assign k_eff = (k == '0) ? DEPTH_W : {1'b0, k};

`ifdef VAR_DELAY_CLEAR_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // IDLE already writes address 0, so IDLE plus CLEAR spans exactly DEPTH cycles
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = S_CLEAR;
            S_CLEAR: if (clr_addr == ADDR_W'(DEPTH - 1)) state_n = S_RUN;
            S_RUN:   state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        clr_we = (state != S_RUN);
        busy   = (state != S_RUN) | reset;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            clr_addr <= '0;
        end else if (clr_we) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        mem_we    = wr_en_p;
        mem_waddr = wr_addr_p;
        mem_wdata = wr_data_p;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = MIDSCALE;
        end
    end
`else
    assign busy      = 1'b0;
    assign mem_we    = wr_en_p;
    assign mem_waddr = wr_addr_p;
    assign mem_wdata = wr_data_p;
`endif

    // The sample write is deferred one cycle so it lands in the same cycle as the
    // read of its own strobe; with k_eff == DEPTH both hit the same address and the
    // read returns the old word, giving an exact DEPTH-sample delay.
    always_ff @(posedge sysclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        ram_rd <= mem[rd_addr];
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            load_d    <= 1'b0;
            wr_ptr    <= '0;
            fill      <= '0;
            v_s1      <= 1'b0;
            mute_s1   <= 1'b0;
            rd_addr   <= '0;
            wr_en_p   <= 1'b0;
            wr_addr_p <= '0;
            wr_data_p <= '0;
            v_s2      <= 1'b0;
            mute_s2   <= 1'b0;
            q         <= MIDSCALE;
            q_valid   <= 1'b0;
        end else begin
            load_d  <= load;
            v_s1    <= stb;
            wr_en_p <= stb;
            if (stb) begin
                wr_addr_p <= wr_ptr;
                wr_data_p <= d;
                // modulo-DEPTH subtraction: k_eff == DEPTH contributes zero low bits
                rd_addr   <= wr_ptr - k_eff[ADDR_W-1:0];
                mute_s1   <= (fill < k_eff);
                wr_ptr    <= wr_ptr + 1'b1;
                if (fill != DEPTH_W) begin
                    fill <= fill + 1'b1;
                end
            end
            v_s2    <= v_s1;
            mute_s2 <= mute_s1;
            q_valid <= v_s2;
            if (v_s2) begin
                q <= mute_s2 ? MIDSCALE : ram_rd;
            end
        end
    end

endmodule
